// File: rtl/decoupled_vr_rr_arbiter_pkg.sv
// Shared types and helpers for the decoupled ready/valid round-robin arbiter.
package decoupled_arb_pkg;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

   localparam int unsigned NumReqDefault    = 32'd4;
   localparam int unsigned DataWidthDefault = 32'd8;

   // Wrap-around increment of a requester index within [0, n).
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      if (idx + 32'd1 >= n) begin
         return 32'd0;
      end else begin
         return idx + 32'd1;
      end
   endfunction

endpackage

// File: rtl/decoupled_vr_rr_arbiter_picker.sv
// Circular find-first: lowest request index at or after ptr, wrapping to 0.
module rr_priority_picker #(
   parameter  int unsigned N = 32'd4,
   localparam int unsigned W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         gnt_valid,
   output logic [W-1:0] gnt_idx
);

   logic [W-1:0] cand_s;

   // Scan farthest-first so the candidate closest to ptr is written last and wins.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      cand_s    = '0;
      for (int k = N - 1; k >= 0; k--) begin
         cand_s = W'((32'(ptr) + 32'(k)) % N);
         if (req[cand_s]) begin
            gnt_valid = 1'b1;
            gnt_idx   = cand_s;
         end else begin
            gnt_valid = gnt_valid;
            gnt_idx   = gnt_idx;
         end
      end
   end

endmodule

// File: rtl/decoupled_vr_rr_arbiter.sv
// Round-robin merge of NumReq ready/valid packet streams into one registered,
// source-tagged output channel; a packet keeps its grant until its last beat.
module decoupled_vr_rr_arbiter
   import decoupled_arb_pkg::*;
#(
   parameter  int unsigned NumReq    = NumReqDefault,
   parameter  int unsigned DataWidth = DataWidthDefault,
   localparam int unsigned IdWidth   = $clog2(NumReq)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NumReq-1:0]           in_valid,
   output logic [NumReq-1:0]           in_ready,
   input  logic [NumReq*DataWidth-1:0] in_data,
   input  logic [NumReq-1:0]           in_last,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [DataWidth-1:0]        out_data,
   output logic                        out_last,
   output logic [IdWidth-1:0]          out_id
);

   arb_state_e           state_q, state_d;
   logic [IdWidth-1:0]   ptr_q, ptr_d;
   logic [IdWidth-1:0]   owner_q, owner_d;
   logic                 out_valid_q, out_valid_d;
   logic [DataWidth-1:0] out_data_q, out_data_d;
   logic                 out_last_q, out_last_d;
   logic [IdWidth-1:0]   out_id_q, out_id_d;

   logic                 pick_valid_s;
   logic [IdWidth-1:0]   pick_idx_s;
   logic                 grant_valid_s;
   logic [IdWidth-1:0]   grant_idx_s;
   logic                 can_accept_s;
   logic                 accept_s;
   logic                 grant_last_s;

   rr_priority_picker #(.N(NumReq)) u_picker (
      .req       (in_valid),
      .ptr       (ptr_q),
      .gnt_valid (pick_valid_s),
      .gnt_idx   (pick_idx_s)
   );

   // Arbitration state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ARB_IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
      end
   end

   // Next state: lock on a non-final beat, release and rotate past the sender on the final one.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      if (accept_s) begin
         if (grant_last_s) begin
            state_d = ARB_IDLE;
            ptr_d   = IdWidth'(rr_next(32'(grant_idx_s), NumReq));
         end else begin
            state_d = ARB_LOCKED;
            owner_d = grant_idx_s;
         end
      end else begin
         state_d = state_q;
      end
   end

   // Grant selection; deliberately independent of out_ready.
   always_comb begin
      grant_valid_s = 1'b0;
      grant_idx_s   = '0;
      case (state_q)
         ARB_IDLE: begin
            grant_valid_s = pick_valid_s;
            grant_idx_s   = pick_idx_s;
         end
         ARB_LOCKED: begin
            grant_valid_s = 1'b1;
            grant_idx_s   = owner_q;
         end
         default: begin
            grant_valid_s = 1'b0;
            grant_idx_s   = '0;
         end
      endcase
   end

   // Handshake toward the requesters; rst_n gates ready so nothing is offered during reset.
   always_comb begin
      can_accept_s = !out_valid_q || out_ready;
      in_ready     = '0;
      if (rst_n && can_accept_s && grant_valid_s) begin
         in_ready[grant_idx_s] = 1'b1;
      end else begin
         in_ready = '0;
      end
      accept_s     = in_valid[grant_idx_s] && in_ready[grant_idx_s];
      grant_last_s = in_last[grant_idx_s];
   end

   // Output stage load/drain; a simultaneous drain and load keeps out_valid high.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      out_id_d    = out_id_q;
      if (accept_s) begin
         out_valid_d = 1'b1;
         out_data_d  = in_data[32'(grant_idx_s) * DataWidth +: DataWidth];
         out_last_d  = grant_last_s;
         out_id_d    = grant_idx_s;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // Output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_id_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         out_id_q    <= out_id_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign out_id    = out_id_q;

endmodule

// File: tb/tb_decoupled_vr_rr_arbiter.sv
// Self-checking bench: reset, fairness table, directed lock/backpressure/bubble/reset
// sequences, then randomized traffic against a packet-level reference model.
module tb_decoupled_vr_rr_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int IW = 2;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   typedef struct {
      logic          out_ready;
      logic [N-1:0]  exp_ready;
      logic          exp_ov;
      logic [IW-1:0] exp_id;
   } vec_t;

   typedef struct {
      int            id;
      logic [DW-1:0] data;
      logic          last;
   } obs_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    in_valid;
   logic [N-1:0]    in_ready;
   logic [N*DW-1:0] in_data;
   logic [N-1:0]    in_last;
   logic            out_valid;
   logic            out_ready;
   logic [DW-1:0]   out_data;
   logic            out_last;
   logic [IW-1:0]   out_id;

   decoupled_vr_rr_arbiter #(.NumReq(N), .DataWidth(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_id    (out_id)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Per-requester pending beats, stall flags and the observed output stream.
   beat_t txq [N][$];
   bit    hold [N];
   obs_t  obs [$];

   // Reference model: packet-level arbitration rules plus the one-entry output register.
   bit            m_locked;
   int            m_owner;
   int            m_ptr;
   bit            m_ov;
   logic [DW-1:0] m_od;
   bit            m_ol;
   int            m_oid;
   int            acc_idx;

   logic [N-1:0]  s_ready;
   logic          s_ov;
   logic [IW-1:0] s_id;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_locked = 0; m_owner = 0; m_ptr = 0;
      m_ov = 0; m_od = '0; m_ol = 0; m_oid = 0;
      acc_idx = -1;
   endtask

   task automatic apply();
      for (int i = 0; i < N; i++) begin
         if (txq[i].size() > 0 && !hold[i]) begin
            in_valid[i]           = 1'b1;
            in_data[i*DW +: DW]   = txq[i][0].data;
            in_last[i]            = txq[i][0].last;
         end else begin
            in_valid[i] = 1'b0;
            in_last[i]  = 1'b0;
         end
      end
   endtask

   // Compare DUT against the model at the falling edge, then advance the model.
   task automatic step();
      int         g;
      bit         gv;
      bit         can;
      logic [N-1:0] er;
      @(negedge clk);
      gv = 0;
      g  = 0;
      if (m_locked) begin
         gv = 1;
         g  = m_owner;
      end else begin
         for (int k = 0; k < N; k++) begin
            if (!gv && in_valid[(m_ptr + k) % N]) begin
               gv = 1;
               g  = (m_ptr + k) % N;
            end
         end
      end
      can = !m_ov || out_ready;
      er  = (can && gv) ? N'(1 << g) : '0;
      s_ready = in_ready;
      s_ov    = out_valid;
      s_id    = out_id;
      check("in_ready", in_ready, er);
      check("out_valid", out_valid, m_ov);
      check("out_data", out_data, m_od);
      check("out_last", out_last, m_ol);
      check("out_id", out_id, m_oid);
      if (out_valid && out_ready) obs.push_back('{int'(out_id), out_data, out_last});
      acc_idx = -1;
      if (er[g] && in_valid[g]) begin
         acc_idx = g;
         m_ov    = 1;
         m_od    = in_data[g*DW +: DW];
         m_ol    = in_last[g];
         m_oid   = g;
         if (in_last[g]) begin
            m_locked = 0;
            m_ptr    = (g + 1) % N;
         end else begin
            m_locked = 1;
            m_owner  = g;
         end
      end else if (out_ready && m_ov) begin
         m_ov = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic cycle();
      apply();
      step();
      if (acc_idx >= 0) txq[acc_idx].delete(0);
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < N; i++) begin
         txq[i].delete();
         hold[i] = 0;
      end
      out_ready = 1'b1;
      repeat (n) cycle();
   endtask

   task automatic check_obs(input string name, input int idx, input int id, input logic [DW-1:0] data);
      check({name, "_id"}, obs[idx].id, id);
      check({name, "_data"}, obs[idx].data, data);
   endtask

   vec_t tbl [9];

   initial begin
      tbl[0] = '{1'b1, 4'b0001, 1'b0, 2'd0};
      tbl[1] = '{1'b1, 4'b0010, 1'b1, 2'd0};
      tbl[2] = '{1'b1, 4'b0100, 1'b1, 2'd1};
      tbl[3] = '{1'b1, 4'b1000, 1'b1, 2'd2};
      tbl[4] = '{1'b1, 4'b0001, 1'b1, 2'd3};
      tbl[5] = '{1'b0, 4'b0000, 1'b1, 2'd0};
      tbl[6] = '{1'b0, 4'b0000, 1'b1, 2'd0};
      tbl[7] = '{1'b1, 4'b0010, 1'b1, 2'd0};
      tbl[8] = '{1'b1, 4'b0100, 1'b1, 2'd1};

      for (int i = 0; i < N; i++) hold[i] = 0;
      model_reset();
      rst_n     = 1'b0;
      in_valid  = '1;
      in_last   = '1;
      in_data   = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_id", out_id, 0);
      rst_n = 1'b1;

      // Fairness with single-beat packets, including a two-cycle stall.
      for (int i = 0; i < N; i++)
         for (int b = 0; b < 8; b++) txq[i].push_back('{8'(8'h10 + i), 1'b1});
      foreach (tbl[v]) begin
         out_ready = tbl[v].out_ready;
         cycle();
         check("tbl_ready", s_ready, tbl[v].exp_ready);
         check("tbl_out_valid", s_ov, tbl[v].exp_ov);
         check("tbl_out_id", s_id, tbl[v].exp_id);
      end

      // Lock: req1's three-beat packet is contiguous, then req2 then req0.
      drain(4);
      obs.delete();
      txq[1].push_back('{8'hA1, 1'b0});
      txq[1].push_back('{8'hA2, 1'b0});
      txq[1].push_back('{8'hA3, 1'b1});
      cycle();
      txq[0].push_back('{8'hB0, 1'b1});
      txq[2].push_back('{8'hC0, 1'b1});
      repeat (8) cycle();
      check("lock_count", obs.size(), 5);
      check_obs("lock0", 0, 1, 8'hA1);
      check_obs("lock1", 1, 1, 8'hA2);
      check_obs("lock2", 2, 1, 8'hA3);
      check_obs("lock3", 3, 2, 8'hC0);
      check_obs("lock4", 4, 0, 8'hB0);

      // Backpressure: held beat stays stable, then drain and accept together.
      drain(3);
      obs.delete();
      out_ready = 1'b0;
      txq[0].push_back('{8'hD0, 1'b1});
      txq[1].push_back('{8'hE0, 1'b1});
      cycle();
      repeat (5) begin
         cycle();
         check("bp_no_ready", s_ready, 0);
         check("bp_hold_data", out_data, 8'hE0);
      end
      out_ready = 1'b1;
      repeat (4) cycle();
      check("bp_count", obs.size(), 2);
      check_obs("bp0", 0, 1, 8'hE0);
      check_obs("bp1", 1, 0, 8'hD0);

      // Locked bubble: req3 pauses mid-packet, req0 must wait.
      drain(3);
      obs.delete();
      txq[3].push_back('{8'hF0, 1'b0});
      txq[3].push_back('{8'hF1, 1'b0});
      txq[3].push_back('{8'hF2, 1'b1});
      cycle();
      hold[3] = 1;
      txq[0].push_back('{8'h60, 1'b1});
      repeat (2) begin
         cycle();
         check("bubble_no_req0", s_ready[0], 0);
      end
      hold[3] = 0;
      repeat (6) cycle();
      check("bubble_count", obs.size(), 4);
      check_obs("bubble0", 0, 3, 8'hF0);
      check_obs("bubble1", 1, 3, 8'hF1);
      check_obs("bubble2", 2, 3, 8'hF2);
      check_obs("bubble3", 3, 0, 8'h60);

      // Reset in the middle of a locked packet.
      drain(3);
      txq[2].push_back('{8'h70, 1'b0});
      txq[2].push_back('{8'h71, 1'b0});
      txq[2].push_back('{8'h72, 1'b1});
      repeat (2) cycle();
      apply();
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_in_ready", in_ready, 0);
      model_reset();
      for (int i = 0; i < N; i++) txq[i].delete();
      @(posedge clk);
      #1;
      check("mid_rst_held_valid", out_valid, 0);
      rst_n = 1'b1;
      for (int i = 0; i < N; i++) txq[i].push_back('{8'(8'h30 + i), 1'b1});
      cycle();
      check("post_rst_grant", s_ready, 4'b0001);
      repeat (5) cycle();

      // Randomized traffic with random stalls and mid-packet bubbles.
      repeat (1500) begin
         out_ready = ($urandom_range(0, 99) < 70);
         for (int i = 0; i < N; i++) begin
            if (txq[i].size() == 0 && $urandom_range(0, 3) == 0) begin
               int len;
               len = int'($urandom_range(1, 4));
               for (int b = 0; b < len; b++) txq[i].push_back('{8'($urandom), (b == len - 1)});
            end
            if (!in_valid[i] || acc_idx == i) hold[i] = ($urandom_range(0, 4) == 0);
         end
         cycle();
      end
      drain(6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
